// File: rtl/chroni_vram_responder.sv
// rtl/chroni_vram_responder.sv - paged VRAM responder for chroni fetch port
// Answers chroni rd_req with rd_ack/rd_data after READ_LATENCY cycles; CPU writes win over fetches.
module chroni_vram_responder #(
    parameter int          PAGES         = 4,
    parameter int          READ_LATENCY  = 1,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic [12:0] rd_addr,
    input  logic [7:0]  rd_page,
    output logic        rd_ack,
    output logic [7:0]  rd_data,
    output logic        rd_unmapped,
    input  logic        cpu_we,
    input  logic [12:0] cpu_wr_addr,
    input  logic [7:0]  cpu_wr_page,
    input  logic [7:0]  cpu_wr_data,
    output logic        busy
);

    localparam int         DEPTH    = PAGES * 8192;
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [12:0] addr_q;
    logic [7:0]  page_q;
    logic        rd_ack_q;
    logic [7:0]  rd_data_q;
    logic        rd_unmapped_q;

    logic [7:0]  mem [DEPTH];

    logic          wr_mapped;
    logic [AW-1:0] wr_idx;
    logic          rd_mapped;
    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_byte;

    // Index truncation aliases unmapped pages onto real ones, so the mapped check must gate both paths.
    assign wr_mapped = int'(cpu_wr_page) < PAGES;
    assign wr_idx    = AW'({cpu_wr_page, cpu_wr_addr});
    assign rd_mapped = int'(page_q) < PAGES;
    assign rd_idx    = AW'({page_q, addr_q});
    assign rd_byte   = rd_mapped ? mem[rd_idx] : UNMAPPED_DATA;

    // RAM is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge sys_clk) begin
        if (cpu_we && wr_mapped) begin
            mem[wr_idx] <= cpu_wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            page_q        <= '0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_unmapped_q <= 1'b0;
        end else begin
            rd_ack_q      <= 1'b0;
            rd_unmapped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        addr_q  <= rd_addr;
                        page_q  <= rd_page;
                        cnt_q   <= CNT_INIT;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!cpu_we) begin
                        rd_data_q     <= rd_byte;
                        rd_ack_q      <= 1'b1;
                        rd_unmapped_q <= !rd_mapped;
                        state_q       <= DROP;
                    end
                end
                DROP: begin
                    // chroni drops rd_req one edge late; wait it out without re-acking.
                    if (!rd_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_ack      = rd_ack_q;
    assign rd_data     = rd_data_q;
    assign rd_unmapped = rd_unmapped_q;
    assign busy        = (state_q != IDLE);

endmodule
